// File: rtl/router_dst_port.sv
// Destination-side output channel of the 1x3 router: tagged byte FIFO with registered read port,
// packet byte tracking and a stall timeout that flushes the channel.
module router_dst_port #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic             full,
  output logic             soft_reset,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = WIDTH - 1;
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  state_t        state, state_next;
  logic [TW-1:0] timer, timer_next;

  logic [WIDTH:0]  mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_next;
  logic [PW-1:0]   pkt_cnt;
  logic            flush, stall, pop_ok, push_ok;
  logic [WIDTH:0]  rd_word;

  assign flush      = (state == S_FLUSH);
  assign soft_reset = flush;
  assign stall      = valid_out && !read_enb;
  // A pop frees a slot on the same edge, so a push is accepted even when full.
  assign pop_ok     = read_enb && valid_out && !flush;
  assign push_ok    = write_enb && (!full || pop_ok) && !flush;
  assign rd_word    = mem[rd_ptr];
  assign count_next = count + (AW + 1)'(push_ok) - (AW + 1)'(pop_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      timer <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
    end
  end

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      S_IDLE: begin
        timer_next = '0;
        if (stall) begin
          state_next = S_WAIT;
          timer_next = TW'(1);
        end
      end
      S_WAIT: begin
        if (!stall) begin
          state_next = S_IDLE;
          timer_next = '0;
        end else if (timer == TMAX) begin
          state_next = S_FLUSH;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      S_FLUSH: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
      default: begin
        state_next = S_IDLE;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr] <= {lfd_state, data_in};
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      full      <= 1'b0;
      data_out  <= '0;
      pkt_cnt   <= '0;
    end else begin
      count     <= count_next;
      valid_out <= (count_next != '0);
      full      <= (count_next == FULL_CNT);
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= rd_word[WIDTH-1:0];
        if (rd_word[WIDTH])
          pkt_cnt <= {1'b0, rd_word[WIDTH-1:2]} + PW'(1);
        else if (pkt_cnt != '0)
          pkt_cnt <= pkt_cnt - PW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      overflow <= 1'b0;
    else if (write_enb && full && !pop_ok && !flush)
      overflow <= 1'b1;
  end

endmodule

// File: tb/tb_router_dst_port.sv
// Bench for router_dst_port: packet table, hand-built corner sequences and randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_router_dst_port;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned TIMEOUT = 30;

  logic             clock = 1'b0;
  logic             reset, write_enb, lfd_state, read_enb;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out, full, soft_reset, overflow;

  router_dst_port #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .write_enb(write_enb), .lfd_state(lfd_state),
    .data_in(data_in), .read_enb(read_enb), .data_out(data_out), .valid_out(valid_out),
    .full(full), .soft_reset(soft_reset), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: byte queue with tag bit, plus stall-run counter.
  logic [WIDTH:0]   q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_ovf, m_flushing;
  int               m_run, m_pkt;

  typedef struct {
    bit         we, lfd, re;
    logic [7:0] din;
    bit         e_valid, e_full;
    logic [7:0] e_dout;
    int         e_pkt;
  } vec_t;
  vec_t vec[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit we, input bit lfd, input logic [7:0] din,
                            input bit re, input bit rst);
    int n;
    bit pop, push;
    logic [WIDTH:0] e;
    if (rst) begin
      q.delete(); m_dout = '0; m_ovf = 0; m_flushing = 0; m_run = 0; m_pkt = 0;
    end else if (m_flushing) begin
      q.delete(); m_dout = '0; m_pkt = 0; m_run = 0; m_flushing = 0;
    end else begin
      n    = q.size();
      pop  = re && (n > 0);
      push = we && ((n < DEPTH) || pop);
      if (we && !push) m_ovf = 1;
      if (pop) begin
        e = q.pop_front();
        m_dout = e[WIDTH-1:0];
        if (e[WIDTH]) m_pkt = int'(e[WIDTH-1:2]) + 1;
        else if (m_pkt > 0) m_pkt = m_pkt - 1;
      end
      if (push) q.push_back({lfd, din});
      if (n > 0 && !re) begin
        m_run++;
        if (m_run == TIMEOUT) begin
          m_flushing = 1;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic step(input bit we, input bit lfd, input logic [7:0] din,
                      input bit re, input bit rst);
    reset = rst; write_enb = we; lfd_state = lfd; data_in = din; read_enb = re;
    @(posedge clock);
    model_edge(we, lfd, din, re, rst);
    #1;
    chk("valid_out", 32'(valid_out), 32'(q.size() != 0));
    chk("full", 32'(full), 32'(q.size() == DEPTH));
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("soft_reset", 32'(soft_reset), 32'(m_flushing));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("pkt_cnt", 32'(dut.pkt_cnt), 32'(m_pkt));
  endtask

  initial begin
    int cnt;
    bit seen;
    reset = 1; write_enb = 0; lfd_state = 0; data_in = '0; read_enb = 0;

    // Packet: header 0x0C (length 3), three payload bytes, parity; then read on empty.
    vec[0]  = '{1, 1, 0, 8'h0C, 1, 0, 8'h00, 0};
    vec[1]  = '{1, 0, 0, 8'h11, 1, 0, 8'h00, 0};
    vec[2]  = '{1, 0, 0, 8'h22, 1, 0, 8'h00, 0};
    vec[3]  = '{1, 0, 0, 8'h33, 1, 0, 8'h00, 0};
    vec[4]  = '{1, 0, 0, 8'hA5, 1, 0, 8'h00, 0};
    vec[5]  = '{0, 0, 1, 8'h00, 1, 0, 8'h0C, 4};
    vec[6]  = '{0, 0, 1, 8'h00, 1, 0, 8'h11, 3};
    vec[7]  = '{0, 0, 1, 8'h00, 1, 0, 8'h22, 2};
    vec[8]  = '{0, 0, 1, 8'h00, 1, 0, 8'h33, 1};
    vec[9]  = '{0, 0, 1, 8'h00, 0, 0, 8'hA5, 0};
    vec[10] = '{0, 0, 1, 8'h00, 0, 0, 8'hA5, 0};

    // Reset held two cycles with write_enb high.
    step(1, 0, 8'h5A, 0, 1);
    step(1, 0, 8'h5A, 0, 1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_dout", 32'(data_out), 32'h00);

    for (int i = 0; i < 11; i++) begin
      step(vec[i].we, vec[i].lfd, vec[i].din, vec[i].re, 0);
      chk($sformatf("tbl%0d_valid", i), 32'(valid_out), 32'(vec[i].e_valid));
      chk($sformatf("tbl%0d_full", i), 32'(full), 32'(vec[i].e_full));
      chk($sformatf("tbl%0d_dout", i), 32'(data_out), 32'(vec[i].e_dout));
      chk($sformatf("tbl%0d_pkt", i), 32'(dut.pkt_cnt), 32'(vec[i].e_pkt));
    end

    // Fill to full, overflow, push+pop at full, drain.
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 0, 8'(i + 1), 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf0", 32'(overflow), 32'd0);
    step(1, 0, 8'hEE, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'(8'h40 + i), 1, 0);
      chk("pp_full", 32'(full), 32'd1);
      chk("pp_dout", 32'(data_out), 32'(i + 1));
    end
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1, 0);
      chk("drain_order", 32'(data_out), (i < 12) ? 32'(i + 5) : 32'(8'h40 + i - 12));
    end
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Timeout: one byte, never read.
    step(0, 0, 0, 0, 1);
    step(1, 0, 8'h77, 0, 0);
    cnt = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step(0, 0, 0, 0, 0);
      cnt++;
      if (soft_reset) seen = 1;
    end
    chk("timeout_seen", 32'(seen), 32'd1);
    chk("timeout_cycles", 32'(cnt), 32'(TIMEOUT));
    step(1, 0, 8'h99, 0, 0);
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_dout", 32'(data_out), 32'h00);
    chk("flush_pulse", 32'(soft_reset), 32'd0);

    // Stall 29, pop, then the timer restarts.
    step(0, 0, 0, 0, 1);
    step(1, 0, 8'hA1, 0, 0);
    step(1, 0, 8'hB2, 0, 0);
    for (int i = 0; i < 28; i++) step(0, 0, 0, 0, 0);
    chk("stall29_nosr", 32'(soft_reset), 32'd0);
    step(0, 0, 0, 1, 0);
    chk("stall29_pop", 32'(data_out), 32'hA1);
    for (int i = 0; i < 29; i++) begin
      step(0, 0, 0, 0, 0);
      chk("restart_nosr", 32'(soft_reset), 32'd0);
    end
    step(0, 0, 0, 0, 0);
    chk("restart_sr", 32'(soft_reset), 32'd1);

    // Randomized traffic in bursts of varying read pressure.
    step(0, 0, 0, 0, 1);
    for (int b = 0; b < 40; b++) begin
      int rp, wp, len;
      rp  = (b % 4 == 0) ? 0 : int'($urandom_range(10, 90));
      wp  = int'($urandom_range(20, 90));
      len = int'($urandom_range(20, 60));
      for (int c = 0; c < len; c++) begin
        step(($urandom_range(0, 99) < wp), ($urandom_range(0, 3) == 0), 8'($urandom),
             ($urandom_range(0, 99) < rp), ($urandom_range(0, 199) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
